// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side master for a synchronous one-port RAM with a
// one-cycle registered read. On start it reads len words upward from
// base_addr and streams them on a valid/ready port. A 2-entry output buffer
// hides the RAM latency and the downstream backpressure.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state_q,    state_d;
  logic                  warm_q,     warm_d;      // first RUN cycle: address settling, no issue
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH:0]   remain_q,   remain_d;    // reads still to issue
  logic [ADDR_WIDTH:0]   left_q,     left_d;      // beats still to hand out
  logic                  pending_q,  pending_d;   // a read is in flight
  logic [1:0]            count_q,    count_d;     // buffer occupancy
  logic [DATA_WIDTH-1:0] buf0_q,     buf0_d;      // buffer head
  logic [DATA_WIDTH-1:0] buf1_q,     buf1_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ_after_pop;

  assign m_valid       = (count_q != 2'd0);
  assign m_data        = buf0_q;
  assign m_last        = m_valid && (left_q == CNT_ONE);
  assign pop           = m_valid && m_ready;
  assign push          = pending_q;
  assign occ_after_pop = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
  // A read is issued only if the word it returns is guaranteed a buffer slot.
  assign issue         = (state_q == S_RUN) && !warm_q && (remain_q != '0) &&
                         (occ_after_pop < 3'd2);

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign ram_addr = ram_addr_q;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;

  // Transfer control: capture parameters on start, walk the address, count beats.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    warm_d     = 1'b0;
    ram_addr_d = ram_addr_q;
    remain_d   = remain_q;
    left_d     = left_q;
    pending_d  = issue;

    if (issue) begin
      ram_addr_d = ram_addr_q + 1'b1;
      remain_d   = remain_q - CNT_ONE;
    end
    if (pop) begin
      left_d = left_q - CNT_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ram_addr_d = base_addr;
          remain_d   = len;
          left_d     = len;
          warm_d     = 1'b1;
          state_d    = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (remain_q == CNT_ONE)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (left_q == CNT_ONE)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer: push returning RAM words behind the head, pop on handshake.
  always_comb begin
    count_d = count_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = ram_dout;
        else                 buf1_d = ram_dout;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = ram_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_dout;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the two buffer words are reset as well: they drive m_data, which
    // must read 0 out of reset, and two flops cost nothing to clear.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      warm_q     <= 1'b0;
      ram_addr_q <= '0;
      remain_q   <= '0;
      left_q     <= '0;
      pending_q  <= 1'b0;
      count_q    <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      warm_q     <= warm_d;
      ram_addr_q <= ram_addr_d;
      remain_q   <= remain_d;
      left_q     <= left_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: RAM model, behavioural expected-beat queue,
// per-cycle compare process, and directed plus randomized transfers.
module tb_ram_stream_reader;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, ram_we, m_valid, m_ready, m_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout, m_data;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // Model state.
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_data [$];
  int            got_cyc  [$];
  logic          got_last [$];
  logic          model_busy = 1'b0;
  logic          done_due   = 1'b0;
  logic          lat_active = 1'b0;
  int            lat_cnt    = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int            cyc        = 0;
  int            done_cnt   = 0;
  logic          rand_ready = 1'b0;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .len(len), .busy(busy), .done(done), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // One-port RAM, one-cycle registered read.
  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer readiness: always ready, or a coin flip each cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: sample between edges, check against the model, then advance it.
  always @(negedge clk) begin
    logic was_busy;
    logic next_done;
    if (!reset_n) begin
      exp_q.delete();
      model_busy = 1'b0;
      done_due   = 1'b0;
      lat_active = 1'b0;
      stall_prev = 1'b0;
    end else begin
      cyc++;
      was_busy  = model_busy;
      next_done = 1'b0;
      check("done", done, done_due);
      check("busy", busy, model_busy);
      check("ram_we", ram_we, 0);
      check("ram_din", ram_din, 0);
      if (!model_busy) check("idle_valid", m_valid, 0);
      check("last", m_last, m_valid && (exp_q.size() == 1));
      if (lat_active) begin
        lat_cnt++;
        check("first_valid_latency", m_valid, lat_cnt == 4);
        if (lat_cnt == 4) lat_active = 1'b0;
      end
      if (stall_prev) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
      end
      if (m_valid && m_ready && model_busy) begin
        check("data", m_data, exp_q[0]);
        void'(exp_q.pop_front());
        got_data.push_back(m_data);
        got_cyc.push_back(cyc);
        got_last.push_back(m_last);
        if (exp_q.size() == 0) begin
          next_done  = 1'b1;
          model_busy = 1'b0;
        end
      end
      if (start && !was_busy && !done_due) begin
        if (len == '0) begin
          next_done = 1'b1;
        end else begin
          model_busy = 1'b1;
          for (int i = 0; i < int'(len); i++)
            exp_q.push_back(mem[(int'(base_addr) + i) % DEPTH]);
          lat_active = 1'b1;
          lat_cnt    = 0;
        end
      end
      if (done) done_cnt++;
      done_due   = next_done;
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  task automatic kick(input int b, input int l, input logic rr);
    rand_ready = rr;
    got_data.delete();
    got_cyc.delete();
    got_last.delete();
    @(posedge clk);
    #1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input int max_cyc);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", done_cnt != d0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    logic [DW-1:0] t2 [4];
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: identity RAM, base 5, len 4, always ready.
    kick(5, 4, 1'b0);
    wait_done(100);
    check("t1_count", got_data.size(), 4);
    if (got_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_data", got_data[i], 5 + i);
        check("t1_back_to_back", got_cyc[i] - got_cyc[0], i);
      end
      check("t1_last_on_8", got_last[3], 1);
      check("t1_no_early_last", got_last[2], 0);
    end

    // 2: address wrap 1022,1023,0,1.
    t2[0] = 8'd254; t2[1] = 8'd255; t2[2] = 8'd0; t2[3] = 8'd1;
    kick(1022, 4, 1'b0);
    wait_done(100);
    check("t2_count", got_data.size(), 4);
    if (got_data.size() == 4)
      for (int i = 0; i < 4; i++) check("t2_data", got_data[i], t2[i]);

    // 3: zero length, done one cycle after the start edge.
    got_data.delete();
    @(posedge clk);
    #1;
    base_addr = 10'd77;
    len       = '0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t3_done_pulse", done, 1);
    check("t3_busy_low", busy, 0);
    @(posedge clk);
    #1 check("t3_done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    check("t3_no_beats", got_data.size(), 0);

    // Random RAM contents from here on.
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

    // 4: base 0, len 8, random backpressure.
    kick(0, 8, 1'b1);
    wait_done(500);
    check("t4_count", got_data.size(), 8);

    // Random transfers.
    for (int k = 0; k < 6; k++) begin
      kick(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
      wait_done(1000);
    end

    // 5a: second start mid-transfer is ignored.
    kick(0, 20, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    base_addr = 10'd300;
    len       = 11'd3;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1000);
    check("t5_count", got_data.size(), 20);
    if (got_data.size() > 0) check("t5_first", got_data[0], mem[0]);

    // 5b: asynchronous reset mid-transfer, then a fresh transfer.
    kick(100, 50, 1'b1);
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    kick(700, 6, 1'b1);
    wait_done(500);
    check("t5_after_reset_count", got_data.size(), 6);
    if (got_data.size() > 0) check("t5_after_reset_first", got_data[0], mem[700]);

    // 6: full sweep, always ready.
    kick(200, DEPTH, 1'b0);
    wait_done(3000);
    check("t6_count", got_data.size(), DEPTH);
    if (got_data.size() == DEPTH) begin
      check("t6_no_bubbles", got_cyc[DEPTH-1] - got_cyc[0], DEPTH - 1);
      check("t6_last_word", got_data[DEPTH-1], mem[199]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
